// File: rtl/chess_pkg.sv
// chess_pkg: shared move encoding, piece/colour codes and merger FSM states
package chess_pkg;
  localparam int MOVE_W = 19;
  localparam logic [MOVE_W-1:0] PVOID = '0;
  localparam int FROM_LSB = 13;
  localparam int TO_LSB = 7;
  localparam int PIECE_LSB = 4;
  localparam int COLOUR_LSB = 3;
  localparam int PROMO_LSB = 0;
  typedef enum logic [2:0] {P_NONE, P_PAWN, P_KNIGHT, P_BISHOP, P_ROOK, P_QUEEN, P_KING} piece_t;
  typedef enum logic {WHITE, BLACK} colour_t;
  typedef enum logic {SCAN, DRAIN} ms_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant, first requester at or above ptr with wrap
module rr_arbiter #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [N-1:0] rot;
  logic [W:0] s;
  always_comb begin
    rot = N'({req, req} >> ptr);
    s = '0;
    any = 1'b0;
    for (int j = N - 1; j >= 0; j--)
      if (rot[j]) begin
        s = (W+1)'(ptr) + (W+1)'(j);
        any = 1'b1;
      end
    idx = s >= (W+1)'(N) ? W'(s - (W+1)'(N)) : W'(s);
    grant = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/move_stream_merger.sv
// move_stream_merger: round-robin merge of column FIFO move words into one move stream
module move_stream_merger #(
  parameter int N_COL = 8,
  parameter int MOVES_PER_WORD = 8,
  parameter int MOVE_W = chess_pkg::MOVE_W,
  parameter int WORD_W = 160,
  parameter int CNT_W = 16,
  parameter int CH_W = $clog2(N_COL)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_COL*WORD_W-1:0] fifo_out,
  input  logic [N_COL-1:0]        fifo_empty,
  output logic [N_COL-1:0]        rden,
  input  logic [N_COL-1:0]        col_done,
  output logic [MOVE_W-1:0]       mv_data,
  output logic [CH_W-1:0]         mv_src,
  output logic                    mv_valid,
  input  logic                    mv_ready,
  output logic [CNT_W-1:0]        mv_count,
  output logic                    all_done
);
  import chess_pkg::*;
  localparam int PW = MOVES_PER_WORD * MOVE_W;
  localparam int SW = $clog2(MOVES_PER_WORD);
  ms_state_t state;
  logic [CH_W-1:0] ptr, gidx;
  logic [N_COL-1:0] grant;
  logic gany, acc, unused;
  logic [PW-1:0] word, in_word;
  logic [PW-1:0] heads [N_COL];
  logic [MOVES_PER_WORD-1:0] mask, in_mask, nxt_mask;
  logic [MOVE_W-1:0] slot [MOVES_PER_WORD];
  logic [SW-1:0] sel;
  rr_arbiter #(.N(N_COL), .W(CH_W)) u_arb (
    .req(~fifo_empty),
    .ptr(ptr),
    .grant(grant),
    .idx(gidx),
    .any(gany)
  );
  always_comb begin
    unused = ^fifo_out;
    for (int c = 0; c < N_COL; c++) heads[c] = fifo_out[c*WORD_W +: PW];
    in_word = heads[gidx];
    sel = '0;
    for (int k = MOVES_PER_WORD - 1; k >= 0; k--) begin
      slot[k] = word[PW-1-k*MOVE_W -: MOVE_W];
      in_mask[k] = in_word[PW-1-k*MOVE_W -: MOVE_W] != PVOID;
      if (mask[k]) sel = SW'(k);
    end
    mv_valid = state == DRAIN && |mask;
    mv_data = mv_valid ? slot[sel] : '0;
    acc = mv_valid && mv_ready;
    nxt_mask = acc ? mask & ~(MOVES_PER_WORD'(1) << sel) : mask;
    // pops happen only while scanning and never in a reset cycle
    rden = state == SCAN && !reset ? grant : '0;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= SCAN;
      ptr <= '0;
      word <= '0;
      mask <= '0;
      mv_src <= '0;
      mv_count <= '0;
      all_done <= 1'b0;
    end else if (state == SCAN) begin
      if (&col_done && &fifo_empty) all_done <= 1'b1;
      if (gany) begin
        word <= in_word;
        mask <= in_mask;
        mv_src <= gidx;
        ptr <= gidx == CH_W'(N_COL - 1) ? '0 : gidx + 1'b1;
        state <= DRAIN;
      end
    end else begin
      mask <= nxt_mask;
      if (acc && !(&mv_count)) mv_count <= mv_count + 1'b1;
      if (nxt_mask == '0) state <= SCAN;
    end
endmodule

// File: tb/tb_move_stream_merger.sv
// tb_move_stream_merger: directed + random checks against a per-channel queue model
module tb_move_stream_merger;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1279:0] fifo_out;
  logic [7:0] fifo_empty, rden, col_done;
  logic [18:0] mv_data;
  logic [2:0] mv_src;
  logic mv_valid, mv_ready, all_done;
  logic [15:0] mv_count;

  move_stream_merger dut (
    .clk(clk), .reset(reset), .fifo_out(fifo_out), .fifo_empty(fifo_empty),
    .rden(rden), .col_done(col_done), .mv_data(mv_data), .mv_src(mv_src),
    .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_count(mv_count), .all_done(all_done)
  );

  always #5 clk = ~clk;

  logic [159:0] q [8][$];
  logic [18:0] eq [8][$];
  logic [18:0] acc_d [$];
  int acc_s [$];
  int n_tests = 0, n_fail = 0, acc = 0, cyc = 0, tb_ptr = 0;
  int rd_pulses [8];
  logic [7:0] last_rd;
  logic last_v, last_ad, stall;
  logic [15:0] last_cnt;
  logic [18:0] pd;
  logic [2:0] ps;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [159:0] mk(input logic [7:0][18:0] sl);
    mk = '0;
    mk[159:152] = 8'($urandom);
    for (int k = 0; k < 8; k++) mk[151-k*19 -: 19] = sl[k];
  endfunction

  function automatic logic [18:0] rnz();
    return 19'($urandom_range(1, 524287));
  endfunction

  task automatic push(input int c, input logic [7:0][18:0] sl);
    q[c].push_back(mk(sl));
    for (int k = 0; k < 8; k++) if (sl[k] != 0) eq[c].push_back(sl[k]);
  endtask

  task automatic push_full(input int c);
    logic [7:0][18:0] sl;
    for (int k = 0; k < 8; k++) sl[k] = rnz();
    push(c, sl);
  endtask

  task automatic drive();
    for (int c = 0; c < 8; c++) begin
      fifo_empty[c] = q[c].size() == 0;
      fifo_out[c*160 +: 160] = q[c].size() ? q[c][0] : '0;
    end
  endtask

  task automatic cycle();
    int e, j;
    logic [18:0] ev;
    drive();
    #4;
    last_rd = rden;
    last_v = mv_valid;
    last_ad = all_done;
    last_cnt = mv_count;
    chk("rden_on_empty", rden & fifo_empty, 0);
    if (reset) tb_ptr = 0;
    if (rden != 0) begin
      e = -1;
      for (int i = 0; i < 8; i++) begin
        j = (tb_ptr + i) % 8;
        if (e < 0 && !fifo_empty[j]) e = j;
      end
      chk("rr_grant", rden, e < 0 ? 8'h0 : 8'(1) << e);
      if (e >= 0) tb_ptr = (e + 1) % 8;
    end
    if (stall) chk("stall_hold", {mv_valid, mv_src, mv_data, rden}, {1'b1, ps, pd, 8'h0});
    if (mv_valid && mv_ready) begin
      ev = '0;
      if (eq[mv_src].size() > 0) ev = eq[mv_src].pop_front();
      chk("sb_move", mv_data, ev);
      acc++;
      acc_d.push_back(mv_data);
      acc_s.push_back(int'(mv_src));
    end
    stall = mv_valid && !mv_ready && !reset;
    pd = mv_data;
    ps = mv_src;
    @(posedge clk);
    #1;
    for (int c = 0; c < 8; c++)
      if (last_rd[c]) begin
        rd_pulses[c]++;
        if (q[c].size() > 0) void'(q[c].pop_front());
      end
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mv_ready = 1'b0;
    col_done = '0;
    for (int c = 0; c < 8; c++) begin
      q[c].delete();
      eq[c].delete();
    end
    repeat (2) cycle();
    reset = 1'b0;
    acc = 0;
    cyc = 0;
    acc_d.delete();
    acc_s.delete();
    for (int c = 0; c < 8; c++) rd_pulses[c] = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0][18:0] sl;
    logic [3:0] h_rd, h_v;
    logic ad [32];
    int c16, order [3], n;
    order = '{0, 2, 5};
    stall = 1'b0;
    mv_ready = 1'b0;
    col_done = '0;
    do_reset();
    chk("rst_valid", mv_valid, 0);
    chk("rst_data", mv_data, 0);
    chk("rst_src", mv_src, 0);
    chk("rst_count", mv_count, 0);
    chk("rst_done", all_done, 0);
    chk("rst_rden", rden, 0);

    // two sparse moves from one word
    do_reset();
    sl = '0;
    sl[0] = 19'h00123;
    sl[2] = 19'h00456;
    push(3, sl);
    mv_ready = 1'b1;
    repeat (12) cycle();
    chk("t1_moves", acc_d.size(), 2);
    chk("t1_first", acc_d[0], 19'h00123);
    chk("t1_second", acc_d[1], 19'h00456);
    chk("t1_src0", acc_s[0], 3);
    chk("t1_src1", acc_s[1], 3);
    chk("t1_pulses", rd_pulses[3], 1);
    chk("t1_count", mv_count, 2);

    // three full words, one scan bubble each
    do_reset();
    push_full(0);
    push_full(2);
    push_full(5);
    mv_ready = 1'b1;
    while (acc < 24 && cyc < 100) cycle();
    chk("t2_cycles", cyc, 27);
    for (int w = 0; w < 3; w++) begin
      chk("t2_src_first", acc_s[w*8], order[w]);
      chk("t2_src_last", acc_s[w*8+7], order[w]);
    end
    chk("t2_count", mv_count, 24);

    // backpressure mid-word
    do_reset();
    push_full(1);
    mv_ready = 1'b1;
    while (acc < 3 && cyc < 50) cycle();
    mv_ready = 1'b0;
    repeat (5) cycle();
    chk("t3_hold_acc", acc, 3);
    chk("t3_hold_valid", last_v, 1);
    mv_ready = 1'b1;
    while (acc < 8 && cyc < 50) cycle();
    chk("t3_total", acc, 8);
    chk("t3_pulses", rd_pulses[1], 1);
    chk("t3_count", mv_count, 8);

    // all-void word followed by a real one on the same channel
    do_reset();
    push(7, '0);
    push_full(7);
    mv_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      h_rd[i] = last_rd[7];
      h_v[i] = last_v;
    end
    chk("t4_rden", h_rd, 4'b0101);
    chk("t4_valid", h_v, 4'b1000);
    while (acc < 8 && cyc < 50) cycle();
    chk("t4_count", mv_count, 8);

    // all_done after final drain
    do_reset();
    col_done = 8'hFF;
    push_full(1);
    push_full(1);
    mv_ready = 1'b1;
    c16 = 0;
    for (int i = 0; i < 25; i++) begin
      cycle();
      ad[cyc] = last_ad;
      if (acc == 16 && c16 == 0) c16 = cyc;
    end
    chk("t5_c16", c16, 18);
    chk("t5_done_at_accept", ad[c16], 0);
    chk("t5_done_at_scan", ad[c16+1], 0);
    chk("t5_done_after", ad[c16+2], 1);
    col_done = '0;
    repeat (3) cycle();
    chk("t5_sticky", all_done, 1);

    // reset in the middle of a drain
    do_reset();
    push_full(2);
    mv_ready = 1'b1;
    repeat (4) cycle();
    push_full(0);
    push_full(4);
    reset = 1'b1;
    mv_ready = 1'b0;
    cycle();
    eq[2].delete();
    cycle();
    chk("t6_valid", last_v, 0);
    chk("t6_count", last_cnt, 0);
    chk("t6_rden", last_rd, 0);
    reset = 1'b0;
    acc = 0;
    cyc = 0;
    cycle();
    chk("t6_first_grant", last_rd, 8'h01);
    mv_ready = 1'b1;
    while (acc < 16 && cyc < 60) cycle();
    chk("t6_total", mv_count, 16);

    // random traffic
    do_reset();
    repeat (800) begin
      if ($urandom_range(0, 5) == 0) begin
        for (int k = 0; k < 8; k++) sl[k] = $urandom_range(0, 9) < 3 ? 19'h0 : rnz();
        push(int'($urandom_range(0, 7)), sl);
      end
      mv_ready = $urandom_range(0, 9) < 7;
      cycle();
    end
    mv_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) n += q[c].size() + eq[c].size();
    while (n > 0 && cyc < 4000) begin
      cycle();
      n = 0;
      for (int c = 0; c < 8; c++) n += q[c].size() + eq[c].size();
    end
    repeat (3) cycle();
    chk("rand_left", n, 0);
    chk("rand_count", mv_count, 16'(acc));
    chk("rand_idle", mv_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
